// File: rtl/controle_busca.sv
// Fetch/PC sequencer: holds the PC, fetches over req/ack, decodes the next-PC select code.
// Optional macro PC_RETIRED_COUNT_EN adds the instr_retiradas retired-instruction counter.
module controle_busca #(
    parameter logic [31:0] PC_RESET      = 32'h0040_0000,
    parameter int          FETCH_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_dado,
    output logic [31:0] instrucao,
    output logic [31:0] pc,
    output logic [31:0] pc_mais_4,
    output logic [31:0] jump_jal,
    output logic [31:0] beq_bne_bgez_bgezal,
    output logic [2:0]  chaves,
    input  logic [31:0] prox_pc,
`ifdef PC_RETIRED_COUNT_EN
    output logic [31:0] instr_retiradas,
`endif
    output logic        exec,
    output logic        halt,
    output logic        erro
);

    localparam int CNT_W = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(FETCH_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_FETCH = 2'b00,
        ST_EXEC  = 2'b01,
        ST_HALT  = 2'b10,
        ST_ERRO  = 2'b11
    } estado_t;

    estado_t          estado_q, estado_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      instr_q, instr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ativo_q, ativo_d;
    logic             eh_syscall_s;

    function automatic logic [2:0] decodifica_chaves(input logic [31:0] ins);
        logic [2:0] sel;
        case (ins[31:26])
            6'b000010, 6'b000011: sel = 3'b001;
            6'b000100, 6'b000101, 6'b000001: sel = 3'b011;
            6'b000000: begin
                if ((ins[5:0] == 6'b001000) || (ins[5:0] == 6'b001001)) begin
                    sel = 3'b010;
                end else begin
                    sel = 3'b000;
                end
            end
            default: sel = 3'b000;
        endcase
        return sel;
    endfunction

    assign eh_syscall_s = (instr_q[31:26] == 6'b000000) && (instr_q[5:0] == 6'b001100);

    // State register and datapath flops; ativo_q keeps imem_req low until the first edge after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado_q <= ST_FETCH;
            pc_q     <= PC_RESET;
            instr_q  <= 32'h0000_0000;
            cnt_q    <= '0;
            ativo_q  <= 1'b0;
        end else begin
            estado_q <= estado_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            cnt_q    <= cnt_d;
            ativo_q  <= ativo_d;
        end
    end

    // Next-state logic: fetch handshake with timeout, single execute cycle, absorbing halt/error.
    always_comb begin
        estado_d = estado_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        cnt_d    = cnt_q;
        ativo_d  = 1'b1;
        case (estado_q)
            ST_FETCH: begin
                if (!ativo_q) begin
                    cnt_d = '0;
                end else if (imem_ack) begin
                    instr_d  = imem_dado;
                    cnt_d    = '0;
                    estado_d = ST_EXEC;
                end else if (cnt_q == CNT_LIM) begin
                    cnt_d    = '0;
                    estado_d = ST_ERRO;
                end else begin
                    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_EXEC: begin
                pc_d = prox_pc;
                if (eh_syscall_s) begin
                    estado_d = ST_HALT;
                end else begin
                    estado_d = ST_FETCH;
                end
            end
            ST_HALT: estado_d = ST_HALT;
            ST_ERRO: estado_d = ST_ERRO;
            default: estado_d = ST_ERRO;
        endcase
    end

    // Moore outputs decoded from state and the latched instruction.
    always_comb begin
        imem_req = 1'b0;
        exec     = 1'b0;
        halt     = 1'b0;
        erro     = 1'b0;
        chaves   = 3'b100;
        case (estado_q)
            ST_FETCH: imem_req = ativo_q;
            ST_EXEC: begin
                exec   = 1'b1;
                chaves = decodifica_chaves(instr_q);
            end
            ST_HALT: halt = 1'b1;
            ST_ERRO: erro = 1'b1;
            default: erro = 1'b1;
        endcase
    end

    assign pc                  = pc_q;
    assign imem_addr           = pc_q;
    assign instrucao           = instr_q;
    assign pc_mais_4           = pc_q + 32'd4;
    assign jump_jal            = {pc_mais_4[31:28], instr_q[25:0], 2'b00};
    assign beq_bne_bgez_bgezal = pc_mais_4 + {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

`ifdef PC_RETIRED_COUNT_EN
    logic [31:0] ret_q, ret_d;

    // Retired-instruction counter, one per execute cycle, wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ret_q <= 32'h0000_0000;
        end else begin
            ret_q <= ret_d;
        end
    end

    // Increment on every execute cycle, syscall included.
    always_comb begin
        if (estado_q == ST_EXEC) begin
            ret_d = ret_q + 32'd1;
        end else begin
            ret_d = ret_q;
        end
    end

    assign instr_retiradas = ret_q;
`endif

endmodule

// File: tb/tb_controle_busca.sv
// Scoreboard bench for controle_busca: memory and next-PC selector models around the DUT.
module tb_controle_busca;

    localparam logic [31:0] PC_RST = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req, imem_ack, exec, halt, erro;
    logic [31:0] imem_addr, imem_dado, instrucao, pc, pc_mais_4, jump_jal, br_alvo, prox_pc;
    logic [2:0]  chaves;
`ifdef PC_RETIRED_COUNT_EN
    logic [31:0] instr_retiradas;
`endif

    controle_busca dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_dado(imem_dado), .instrucao(instrucao), .pc(pc),
        .pc_mais_4(pc_mais_4), .jump_jal(jump_jal), .beq_bne_bgez_bgezal(br_alvo),
        .chaves(chaves), .prox_pc(prox_pc),
`ifdef PC_RETIRED_COUNT_EN
        .instr_retiradas(instr_retiradas),
`endif
        .exec(exec), .halt(halt), .erro(erro)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic        zero;
        logic [31:0] jr_alvo;
    } prog_t;

    typedef struct {
        logic [31:0] instr, pc, pc4, jmp, br;
        logic [2:0]  ch;
    } esp_t;

    prog_t       prog_q[$];
    esp_t        exp_q[$];
    int          n_aval = 0;
    int          n_falhas = 0;
    logic        mem_on = 1'b0;
    logic        zero_r = 1'b0;
    logic [31:0] jr_r = 32'h0;
    logic [31:0] model_pc = PC_RST;

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        n_aval++;
        if (obs !== esp) begin
            n_falhas++;
            $display("FAIL %s: obtido %h esperado %h", tag, obs, esp);
        end
    endtask

    // Selector model: turns the select code into a next PC.
    always_comb begin
        case (chaves)
            3'b000:  prox_pc = pc_mais_4;
            3'b001:  prox_pc = jump_jal;
            3'b010:  prox_pc = jr_r;
            3'b011:  prox_pc = zero_r ? br_alvo : pc_mais_4;
            default: prox_pc = pc;
        endcase
    end

    function automatic logic [2:0] ch_esperado(input logic [31:0] i);
        if (i[31:26] == 6'd2 || i[31:26] == 6'd3) return 3'b001;
        if (i[31:26] == 6'd4 || i[31:26] == 6'd5 || i[31:26] == 6'd1) return 3'b011;
        if (i[31:26] == 6'd0 && (i[5:0] == 6'h08 || i[5:0] == 6'h09)) return 3'b010;
        return 3'b000;
    endfunction

    // Memory model, scoreboard push on delivery and pop/compare on each execute cycle.
    always @(negedge clk) begin
        if (exec) begin
            if (exp_q.size() == 0) begin
                verifica("exec_sem_esperado", 32'd1, 32'd0);
            end else begin
                esp_t e;
                e = exp_q.pop_front();
                verifica("instrucao", instrucao, e.instr);
                verifica("pc", pc, e.pc);
                verifica("pc_mais_4", pc_mais_4, e.pc4);
                verifica("jump_jal", jump_jal, e.jmp);
                verifica("branch", br_alvo, e.br);
                verifica("chaves", {29'd0, chaves}, {29'd0, e.ch});
                verifica("req_exec", {31'd0, imem_req}, 32'd0);
            end
        end
        if (!reset && imem_req && mem_on && prog_q.size() > 0) begin
            prog_t p;
            esp_t  e;
            p = prog_q.pop_front();
            verifica("imem_addr", imem_addr, model_pc);
            e.instr = p.instr;
            e.pc    = model_pc;
            e.pc4   = model_pc + 32'd4;
            e.jmp   = {e.pc4[31:28], p.instr[25:0], 2'b00};
            e.br    = e.pc4 + {{14{p.instr[15]}}, p.instr[15:0], 2'b00};
            e.ch    = ch_esperado(p.instr);
            case (e.ch)
                3'b001:  model_pc = e.jmp;
                3'b010:  model_pc = p.jr_alvo;
                3'b011:  model_pc = p.zero ? e.br : e.pc4;
                default: model_pc = e.pc4;
            endcase
            exp_q.push_back(e);
            zero_r    = p.zero;
            jr_r      = p.jr_alvo;
            imem_dado = p.instr;
            imem_ack  = 1'b1;
        end else begin
            imem_ack  = 1'b0;
            imem_dado = 32'hDEAD_BEEF;
        end
    end

    task automatic carrega(input logic [31:0] i, input logic z, input logic [31:0] j);
        prog_t p;
        p.instr = i; p.zero = z; p.jr_alvo = j;
        prog_q.push_back(p);
    endtask

    task automatic aguarda_vazio(input string tag);
        int k;
        for (k = 0; k < 100 && (prog_q.size() > 0 || exp_q.size() > 0); k++) @(negedge clk);
        verifica(tag, {31'd0, (prog_q.size() > 0 || exp_q.size() > 0)}, 32'd0);
    endtask

    task automatic reinicia();
        @(negedge clk);
        reset = 1'b1;
        mem_on = 1'b0;
        prog_q.delete();
        exp_q.delete();
        model_pc = PC_RST;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int n, viol;
        imem_ack = 1'b0;
        imem_dado = 32'h0;
        // Reset state.
        #12;
        verifica("rst_req", {31'd0, imem_req}, 32'd0);
        verifica("rst_chaves", {29'd0, chaves}, 32'd4);
        verifica("rst_exec", {31'd0, exec}, 32'd0);
        verifica("rst_pc", pc, PC_RST);
        verifica("rst_halt_erro", {30'd0, halt, erro}, 32'd0);
        verifica("rst_instr", instrucao, 32'd0);

        // Main program ending in syscall.
        carrega(32'h0000_0000, 1'b0, 32'h0);
        carrega(32'h0804_0000, 1'b0, 32'h0);
        carrega(32'h1000_FFFF, 1'b1, 32'h0);
        carrega(32'h1000_FFFF, 1'b0, 32'h0);
        carrega(32'h03E0_0008, 1'b0, 32'h0040_0010);
        carrega(32'h1000_FFFF, 1'b0, 32'h0);
        carrega(32'h1400_0003, 1'b1, 32'h0);
        carrega(32'h0411_FFFE, 1'b1, 32'h0);
        carrega(32'h0C00_0001, 1'b0, 32'h0);
        carrega(32'h0060_F809, 1'b0, 32'hF000_0000);
        carrega(32'h0800_0010, 1'b0, 32'h0);
        carrega(32'h0000_0008, 1'b0, 32'hFFFF_FFFC);
        carrega(32'h2408_0001, 1'b0, 32'h0);
        carrega(32'h0000_000C, 1'b0, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        mem_on = 1'b1;
        @(posedge clk);
        #1 verifica("req_apos_rst", {31'd0, imem_req}, 32'd1);
        for (n = 0; n < 300 && !halt; n++) @(negedge clk);
        verifica("halt", {31'd0, halt}, 32'd1);
        verifica("sb_vazio", exp_q.size() + prog_q.size(), 32'd0);
        verifica("pc_wrap", pc, 32'h0000_0004);
`ifdef PC_RETIRED_COUNT_EN
        verifica("retiradas", instr_retiradas, 32'd14);
`endif
        viol = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (imem_req || exec || !halt || chaves != 3'b100) viol++;
        end
        verifica("halt_parado", viol, 32'd0);

        // Fetch timeout.
        reinicia();
        verifica("halt_limpo", {31'd0, halt}, 32'd0);
        n = 0;
        for (int c = 0; c < 40 && !erro; c++) begin
            @(negedge clk);
            if (imem_req) n++;
        end
        verifica("timeout_ciclos", n, 32'd16);
        verifica("erro", {31'd0, erro}, 32'd1);
        verifica("erro_req", {31'd0, imem_req}, 32'd0);
        verifica("erro_chaves", {29'd0, chaves}, 32'd4);

        // Reset in the middle of a fetch.
        reinicia();
        verifica("erro_limpo", {31'd0, erro}, 32'd0);
        carrega(32'h0000_0000, 1'b0, 32'h0);
        mem_on = 1'b1;
        aguarda_vazio("nop1_feito");
        mem_on = 1'b0;
        repeat (3) @(negedge clk);
        verifica("pc_antes_rst", pc, 32'h0040_0004);
        verifica("req_antes_rst", {31'd0, imem_req}, 32'd1);
        #2 reset = 1'b1;
        #1 verifica("pc_rst_meio", pc, PC_RST);
        verifica("req_rst_meio", {31'd0, imem_req}, 32'd0);
        @(negedge clk);
        model_pc = PC_RST;
        reset = 1'b0;
        carrega(32'h0000_0000, 1'b0, 32'h0);
        mem_on = 1'b1;
        aguarda_vazio("nop2_feito");
        @(negedge clk);
        verifica("pc_reinicio", pc, 32'h0040_0004);

        $display("End of test - %0d assertions evaluated, %0d failures", n_aval, n_falhas);
        $finish;
    end

endmodule

// File: doc/controle_busca.md
Name: controle_busca

Overview:
Fetch/PC sequencer for the MIPS core; it sits on the driving side of the next-PC selector. It holds the PC register and fetches instructions from instruction memory over a req/ack handshake. It decodes each fetched instruction into the 3-bit `chaves` selection code and computes the jump and branch targets the selector consumes. It loads the selector's `prox_pc` result back into the PC once per executed instruction.

Parameters:
- PC_RESET, 32'h0040_0000, PC value loaded on reset (text segment base).
- FETCH_TIMEOUT, 16, cycles `imem_req` may stay unacknowledged before the error state.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  32  fetch address; always equals `pc`.
- imem_ack  input  1  memory has `imem_dado` valid this cycle.
- imem_dado  input  32  instruction word from memory.
- instrucao  output  32  latched current instruction.
- pc  output  32  current PC register.
- pc_mais_4  output  32  pc + 4.
- jump_jal  output  32  jump target.
- beq_bne_bgez_bgezal  output  32  branch target.
- chaves  output  3  next-PC select code to the selector.
- prox_pc  input  32  selected next PC returned by the selector.
- exec  output  1  high during the single execute cycle.
- halt  output  1  sticky, set after syscall.
- erro  output  1  sticky, set on fetch timeout.

Behaviour:
- Reset (async, active-high): state=FETCH, pc=PC_RESET, instrucao=0, wait counter=0, halt=0, erro=0.
- During and out of reset, the outputs settle to: imem_req=0, chaves=3'b100, exec=0. `imem_req` rises in the first cycle after reset deasserts.
- States are FETCH, EXEC, HALT and ERRO; outputs are Moore-style, decoded from state plus `instrucao`.
- FETCH:
  - imem_req=1, chaves=3'b100 (selector holds pc).
  - On imem_ack=1: latch imem_dado into instrucao, clear counter, go to EXEC. An ack in the same cycle req first rises is accepted.
  - Without ack: counter increments. When the counter reaches FETCH_TIMEOUT-1 with no ack, go to ERRO.
- EXEC (exactly 1 cycle):
  - exec=1, imem_req=0, chaves decoded from instrucao.
  - At the clock edge: pc <= prox_pc.
  - Next state is HALT if instrucao is syscall (opcode 0, funct 6'b001100); otherwise FETCH.
- HALT: halt=1, imem_req=0, chaves=3'b100. Held until reset.
- ERRO: erro=1, imem_req=0, chaves=3'b100. Held until reset.
- `imem_ack` outside FETCH is ignored.
- Decode of `chaves` in EXEC, by opcode/funct of instrucao:
  - opcode 6'b000010 (j) or 6'b000011 (jal) -> 3'b001.
  - opcode 0 with funct 6'b001000 (jr) or 6'b001001 (jalr) -> 3'b010.
  - opcode 6'b000100 (beq), 6'b000101 (bne) or 6'b000001 (REGIMM: bgez/bgezal) -> 3'b011. Branch-taken decision stays with `zero` at the selector.
  - Anything else, including syscall -> 3'b000.
- Arithmetic, all combinational and modulo 2^32:
  - pc_mais_4 = pc + 4; wraps at 32'hFFFF_FFFC -> 0.
  - jump_jal = {pc_mais_4[31:28], instrucao[25:0], 2'b00}.
  - beq_bne_bgez_bgezal = pc_mais_4 + (sign-extended instrucao[15:0] << 2).
- Reset mid-FETCH or mid-EXEC aborts immediately; no pc update occurs.

Optional Feature:
- Macro PC_RETIRED_COUNT_EN.
- Defined: adds output `instr_retiradas` [31:0]. Resets to 0, increments by 1 on every EXEC cycle (including syscall), wraps at 2^32.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, memory acks in the same cycle with 32'h0000_0000 (nop), selector attached -> one EXEC cycle with chaves=000; pc goes 32'h0040_0000 -> 32'h0040_0004; next cycle imem_req=1.
- Fetch 32'h0804_0000 (j) at pc 32'h0040_0000 -> in EXEC: chaves=001, jump_jal=32'h0010_0000; pc becomes 32'h0010_0000.
- Fetch 32'h1000_FFFF (beq, imm=-1) at pc 32'h0040_0010 -> beq_bne_bgez_bgezal=32'h0040_0010, chaves=011. pc loads the target if zero=1, otherwise 32'h0040_0014.
- Fetch 32'h03E0_0008 (jr $ra) -> chaves=010, pc <= prox_pc value driven on the jr_jalr path.
- Fetch 32'h0000_000C (syscall) -> EXEC with chaves=000, then halt=1. imem_req stays 0 for 20+ cycles, until reset clears halt.
- Withhold ack for 16 cycles -> erro=1 and imem_req=0. Separately, assert reset mid-FETCH -> pc=32'h0040_0000 immediately and the fetch restarts after release.
